// File: rtl/elm_pkg.sv
// Shared definitions for the weight bank streamer: FSM states and lane slicing.
package elm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    localparam int LANE_DW_DEFAULT = 16;

    // Bit offset of a lane inside the packed multi-lane output word.
    function automatic int lane_lo(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/weight_ram_sdp.sv
// Simple dual-port weight RAM; one write port, one registered read port (latency 1).
// No flow control: the read register only loads on re, so rdata holds otherwise.
module weight_ram_sdp #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // No reset on the array or read register so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/weight_bank_stream.sv
// Streams NUM_NEURONS weight lanes per beat from banked RAM; one beat per cycle, first beat 1 cycle after issue.
// Valid/ready output: a stalled beat holds stable and no further read issues until it is accepted.
module weight_bank_stream
    import elm_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = LANE_DW_DEFAULT,
    parameter int SEL_WIDTH   = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_en,
    input  logic [SEL_WIDTH-1:0]              wr_sel,
    input  logic [ADDR_WIDTH-1:0]             wr_addr,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    output logic                              wr_ack,
    output logic                              wr_err,
    input  logic                              start,
    input  logic [ADDR_WIDTH:0]               rd_len,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_NEURONS*DATA_WIDTH-1:0] out_data,
    output logic                              out_last,
    output logic                              busy,
    output logic                              done
);

    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                            state;
    state_t                            state_nxt;
    logic [ADDR_WIDTH:0]               rd_ptr;
    logic [ADDR_WIDTH:0]               len_q;
    logic [ADDR_WIDTH:0]               len_sat;
    logic                              start_ok;
    logic                              rd_fire;
    logic                              last_rd;
    logic                              accept;
    logic                              wr_ok;
    logic                              done_zero;
    logic [NUM_NEURONS*DATA_WIDTH-1:0] ram_q;

    always_comb begin
        len_sat  = (rd_len > MAX_LEN) ? MAX_LEN : rd_len;
        start_ok = (state == ST_IDLE) && start;
        rd_fire  = (state == ST_STREAM) && (!out_valid || out_ready);
        last_rd  = ((rd_ptr + 1'b1) == len_q);
        accept   = out_valid && out_ready;
        wr_ok    = wr_en && (state == ST_IDLE)
                   && ({1'b0, wr_sel} < (SEL_WIDTH+1)'(NUM_NEURONS));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start_ok && (rd_len != '0)) state_nxt = ST_STREAM;
            ST_STREAM: if (rd_fire && last_rd)         state_nxt = ST_DRAIN;
            ST_DRAIN:  if (accept && out_last)         state_nxt = ST_IDLE;
            default:                                   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rd_ptr    <= '0;
            len_q     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done_zero <= 1'b0;
            wr_ack    <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok && (rd_len != '0)) begin
                len_q  <= len_sat;
                rd_ptr <= '0;
            end else if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // A freshly issued read replaces the beat being accepted this cycle.
            if (rd_fire) begin
                out_valid <= 1'b1;
                out_last  <= last_rd;
            end else if (accept) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            done_zero <= start_ok && (rd_len == '0);
            wr_ack    <= wr_ok;
            wr_err    <= wr_en && !wr_ok;
        end
    end

    for (genvar k = 0; k < NUM_NEURONS; k++) begin : g_lane
        weight_ram_sdp #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_ram (
            .clk   (clk),
            .we    (wr_ok && (wr_sel == SEL_WIDTH'(k))),
            .waddr (wr_addr),
            .wdata (wr_data),
            .re    (rd_fire),
            .raddr (rd_ptr[ADDR_WIDTH-1:0]),
            .rdata (ram_q[lane_lo(k, DATA_WIDTH) +: DATA_WIDTH])
        );
    end

    // Gating by out_valid keeps the bus at zero whenever no beat is presented.
    assign out_data = out_valid ? ram_q : '0;
    assign busy     = (state != ST_IDLE);
    assign done     = done_zero || ((state == ST_DRAIN) && accept && out_last);

endmodule

// File: tb/tb_weight_bank_stream.sv
// Bench for weight_bank_stream: table vectors for idle-time writes/zero-length starts,
// hand sequences for stream corner cases, and randomized streams against a memory model.
module tb_weight_bank_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_sel = '0;
    logic [9:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ack, wr_err;
    logic        start = 1'b0;
    logic [10:0] rd_len = '0;
    logic        out_valid, out_last, busy, done;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;

    weight_bank_stream #(
        .NUM_NEURONS (4),
        .ADDR_WIDTH  (10),
        .DATA_WIDTH  (16),
        .SEL_WIDTH   (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .wr_err    (wr_err),
        .start     (start),
        .rd_len    (rd_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference memory: what each lane should hold at each address.
    logic [15:0] mdl [4][1024];

    function automatic logic [63:0] exp_beat(input int i);
        logic [9:0] a;
        a = 10'(i);
        return {mdl[3][a], mdl[2][a], mdl[1][a], mdl[0][a]};
    endfunction

    typedef struct {
        logic [63:0] d;
        logic        l;
        int          c;
    } beat_t;
    beat_t got[$];
    int    done_c[$];

    // Monitor: records accepted beats and done pulses, checks stalled beats hold.
    logic        pstall = 1'b0;
    logic [63:0] pd;
    logic        pl;
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            pstall = 1'b0;
        end else begin
            if (pstall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", out_data, pd);
                chk("hold_last", 64'(out_last), 64'(pl));
            end
            if (out_valid && out_ready) got.push_back('{out_data, out_last, cyc});
            if (done) done_c.push_back(cyc);
            pstall = out_valid && !out_ready;
            pd     = out_data;
            pl     = out_last;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_last"}, 64'(out_last), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_ack"}, 64'(wr_ack), 64'd0);
        chk({tag, "_err"}, 64'(wr_err), 64'd0);
        chk({tag, "_data"}, out_data, 64'd0);
    endtask

    task automatic do_write(input logic [2:0] sel, input logic [9:0] a, input logic [15:0] d);
        logic ok;
        ok = (sel < 3'd4);
        @(negedge clk);
        wr_en = 1'b1; wr_sel = sel; wr_addr = a; wr_data = d;
        if (ok) mdl[sel[1:0]][a] = d;
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        chk("wr_ack", 64'(wr_ack), 64'(ok));
        chk("wr_err", 64'(wr_err), 64'(!ok));
    endtask

    // One stream: optional stall at a beat index, random ready, an injected
    // write mid-stream, or a write to lane 1 addr 0 issued alongside start.
    task automatic run_stream(input int len, input int stall_beat, input int stall_n,
                              input bit rnd, input bit inj_wr, input bit sw);
        int eff, budget, stall_left;
        bit stalled;
        eff = (len > 1024) ? 1024 : len;
        budget = (rnd ? eff * 6 : eff * 2) + stall_n + 40;
        stall_left = 0;
        stalled = 1'b0;
        got.delete();
        done_c.delete();
        @(negedge clk);
        start = 1'b1; rd_len = 11'(len);
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (sw) begin
            wr_en = 1'b1; wr_sel = 3'd1; wr_addr = 10'd0; wr_data = 16'hBEEF;
            mdl[1][0] = 16'hBEEF;
        end
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        #1;
        if (sw) chk("start_wr_ack", 64'(wr_ack), 64'd1);
        for (int it = 0; it < budget && done_c.size() == 0; it++) begin
            @(negedge clk);
            wr_en = 1'b0;
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else if (!stalled && stall_n > 0 && got.size() == stall_beat && out_valid) begin
                stalled = 1'b1;
                stall_left = stall_n - 1;
                out_ready = 1'b0;
            end else begin
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (inj_wr && it == 2) begin
                wr_en = 1'b1; wr_sel = 3'd0; wr_addr = 10'd0; wr_data = 16'hDEAD;
            end
            if (inj_wr && it == 3) begin
                #1;
                chk("busy_wr_err", 64'(wr_err), 64'd1);
                chk("busy_wr_ack", 64'(wr_ack), 64'd0);
            end
        end
        chk("stream_done_count", 64'(done_c.size()), 64'd1);
        repeat (3) @(negedge clk);
        #1;
        chk("beat_count", 64'(got.size()), 64'(eff));
        chk("busy_after", 64'(busy), 64'd0);
        for (int i = 0; i < got.size() && i < eff; i++) begin
            chk("beat_data", got[i].d, exp_beat(i));
            chk("beat_last", 64'(got[i].l), 64'(i == eff - 1));
            if (!rnd && stall_n == 0 && i > 0)
                chk("beat_gap", 64'(got[i].c - got[i-1].c), 64'd1);
        end
        if (done_c.size() > 0 && got.size() > 0)
            chk("done_with_last", 64'(done_c[0]), 64'(got[got.size()-1].c));
    endtask

    typedef struct {
        logic        wr_en;
        logic [2:0]  wr_sel;
        logic [9:0]  wr_addr;
        logic [15:0] wr_data;
        logic        start;
        logic [10:0] rd_len;
        logic        exp_ack;
        logic        exp_err;
        logic        exp_done;
    } vec_t;
    vec_t vecs[$];

    initial begin
        // Idle-time vectors: lane/addr pattern writes, then rejected and zero-length cases.
        for (int ln = 0; ln < 4; ln++)
            for (int a = 0; a < 4; a++)
                vecs.push_back('{1'b1, 3'(ln), 10'(a), 16'(16'h0100 + 16 * ln + a),
                                 1'b0, 11'd0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 3'd4, 10'd1, 16'hAAAA, 1'b0, 11'd0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 3'd7, 10'd2, 16'h5555, 1'b0, 11'd0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 10'd0, 16'h0000, 1'b1, 11'd0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 3'd2, 10'd500, 16'h1234, 1'b0, 11'd0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 3'd0, 10'd0, 16'h0000, 1'b0, 11'd0, 1'b0, 1'b0, 1'b0});

        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill every address so any stream reads defined contents.
        for (int ln = 0; ln < 4; ln++)
            for (int a = 0; a < 1024; a++)
                do_write(3'(ln), 10'(a), 16'($urandom));

        got.delete();
        done_c.delete();
        foreach (vecs[i]) begin
            @(negedge clk);
            wr_en = vecs[i].wr_en; wr_sel = vecs[i].wr_sel;
            wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
            start = vecs[i].start; rd_len = vecs[i].rd_len;
            if (vecs[i].wr_en && vecs[i].wr_sel < 3'd4)
                mdl[vecs[i].wr_sel[1:0]][vecs[i].wr_addr] = vecs[i].wr_data;
            @(negedge clk);
            wr_en = 1'b0; start = 1'b0;
            #1;
            chk("vec_ack", 64'(wr_ack), 64'(vecs[i].exp_ack));
            chk("vec_err", 64'(wr_err), 64'(vecs[i].exp_err));
            chk("vec_done", 64'(done), 64'(vecs[i].exp_done));
            chk("vec_valid", 64'(out_valid), 64'd0);
        end
        chk("zero_len_no_beat", 64'(got.size()), 64'd0);
        chk("zero_len_done_count", 64'(done_c.size()), 64'd1);

        // Basic four-beat stream with the lane/addr pattern.
        run_stream(4, 0, 0, 1'b0, 1'b0, 1'b0);
        if (got.size() == 4) begin
            chk("beat2_lane3", 64'(got[2].d[63:48]), 64'h0132);
            chk("beat1_lane0_untouched", 64'(got[1].d[15:0]), 64'h0101);
        end

        // Stall at beat 1 for five cycles.
        run_stream(3, 1, 5, 1'b0, 1'b0, 1'b0);

        // Write attempt during a stream is rejected; then read back unchanged data.
        run_stream(8, 0, 0, 1'b0, 1'b1, 1'b0);
        run_stream(4, 0, 0, 1'b0, 1'b0, 1'b0);
        if (got.size() > 0) chk("readback_lane0_addr0", 64'(got[0].d[15:0]), 64'h0100);

        // Reset at beat 2 of an 8-beat stream.
        got.delete();
        done_c.delete();
        @(negedge clk);
        start = 1'b1; rd_len = 11'd8; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int it = 0; it < 40 && got.size() < 2; it++) @(negedge clk);
        chk("reach_beat2", 64'(got.size() >= 2), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        chk("midreset_no_done", 64'(done_c.size()), 64'd0);
        rst_n = 1'b1;
        run_stream(8, 0, 0, 1'b0, 1'b0, 1'b0);

        // Start and lane-1 write in the same cycle.
        run_stream(2, 0, 0, 1'b0, 1'b0, 1'b1);
        if (got.size() > 0) chk("beef_beat0_lane1", 64'(got[0].d[31:16]), 64'hBEEF);

        // Oversized length saturates to the full depth without wrapping.
        run_stream(2000, 0, 0, 1'b0, 1'b0, 1'b0);

        // Randomized writes and streams with random backpressure.
        for (int r = 0; r < 6; r++) begin
            for (int w = 0; w < 5; w++)
                do_write(3'($urandom_range(0, 5)), 10'($urandom_range(0, 63)), 16'($urandom));
            run_stream($urandom_range(1, 40), 0, 0, 1'b1, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/weight_bank_stream.md
WEIGHT_BANK_STREAM -- requirements
Module: weight_bank_stream

Interface
REQ-001 The module SHALL have parameter NUM_NEURONS, default 4, meaning the number of neuron weight lanes read in parallel.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 10, meaning the per-lane address width (depth 2**ADDR_WIDTH).
REQ-003 The module SHALL have parameter DATA_WIDTH, default 16, meaning the weight word width.
REQ-004 The module SHALL have parameter SEL_WIDTH, default 2, meaning the lane-select width, >= clog2(NUM_NEURONS).
REQ-005 The module SHALL have port clk, input, 1, the single clock (all logic on the rising edge).
REQ-006 The module SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-007 The module SHALL have port wr_en, input, 1, a weight write request.
REQ-008 The module SHALL have port wr_sel, input, SEL_WIDTH, the target lane.
REQ-009 The module SHALL have port wr_addr, input, ADDR_WIDTH, the write address.
REQ-010 The module SHALL have port wr_data, input, DATA_WIDTH, the write word.
REQ-011 The module SHALL have port wr_ack, output, 1, write accepted (one-cycle pulse).
REQ-012 The module SHALL have port wr_err, output, 1, write rejected (one-cycle pulse).
REQ-013 The module SHALL have port start, input, 1, a stream start request.
REQ-014 The module SHALL have port rd_len, input, ADDR_WIDTH+1, the beat count, latched on an accepted start.
REQ-015 The module SHALL have port out_valid, output, 1, the output beat valid.
REQ-016 The module SHALL have port out_ready, input, 1, the consumer ready.
REQ-017 The module SHALL have port out_data, output, NUM_NEURONS*DATA_WIDTH, with lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-018 The module SHALL have port out_last, output, 1, marking the final beat.
REQ-019 The module SHALL have port busy, output, 1, high outside IDLE.
REQ-020 The module SHALL have port done, output, 1, a one-cycle pulse on stream completion.

Function
REQ-021 The FSM SHALL have exactly three states, IDLE, STREAM and DRAIN.
REQ-022 In IDLE, start with rd_len>0 SHALL latch rd_len, clear the read address to 0 and move to STREAM.
REQ-023 In IDLE, start with rd_len==0 SHALL pulse done the next cycle, stay in IDLE and emit no beat.
REQ-024 In STREAM, a read of all lanes at address rd_ptr SHALL issue when (!out_valid || out_ready), and rd_ptr SHALL then increment.
REQ-025 RAM read latency SHALL be 1: data read at cycle N appears on out_data with out_valid=1 at cycle N+1.
REQ-026 While out_valid && !out_ready, out_data, out_last and out_valid SHALL hold stable and no read SHALL issue.
REQ-027 When the rd_len-th read issues, the FSM SHALL move to DRAIN, and that beat SHALL carry out_last=1.
REQ-028 In DRAIN, the out_last beat accepted (out_valid && out_ready) SHALL return the FSM to IDLE and pulse done in the same cycle as the acceptance.
REQ-029 A start outside IDLE SHALL be ignored.
REQ-030 A write SHALL be accepted only in IDLE with wr_sel<NUM_NEURONS; the RAM SHALL update on that edge, and wr_ack SHALL pulse the next cycle.
REQ-031 A write in STREAM or DRAIN, or with wr_sel>=NUM_NEURONS, SHALL not modify memory and SHALL pulse wr_err the next cycle.
REQ-032 A simultaneous start and wr_en in IDLE SHALL accept both; the write is completed before the first read, so a write to address 0 is visible on beat 0.
REQ-033 rd_len values above 2**ADDR_WIDTH SHALL saturate to 2**ADDR_WIDTH, and the address SHALL not wrap within a stream.

Reset
REQ-034 Asserting rst_n low SHALL immediately force IDLE, out_valid=0, out_last=0, busy=0, done=0, wr_ack=0, wr_err=0, out_data=0 and rd_ptr=0.
REQ-035 Reset mid-stream SHALL abort the stream with no done pulse, and RAM contents SHALL not be cleared.

Structure
REQ-036 A shared package elm_pkg SHALL hold the FSM state enum and the lane-slice width constants.
REQ-037 One sub-module, weight_ram_sdp, SHALL be instantiated NUM_NEURONS times: simple dual-port, registered read, ram_style block.

Verification
REQ-038 Bench SHALL cover: write lane0/1/2/3 addr0..3 = 16'h0100+16*lane+addr, start rd_len=4, ready=1 -> 4 consecutive beats, beat 2 lane 3 = 16'h0132, out_last on beat 3, done with beat 3.
REQ-039 Bench SHALL cover: rd_len=3, out_ready low for 5 cycles at beat 1 -> beat 1 held stable, no beat lost or duplicated, 3 beats total.
REQ-040 Bench SHALL cover: start with rd_len=0 -> done one cycle later, out_valid never high.
REQ-041 Bench SHALL cover: wr_en during STREAM, and wr_sel=4 in IDLE -> wr_err pulses, following readback unchanged.
REQ-042 Bench SHALL cover: rst_n low at beat 2 of an 8-beat stream -> outputs zero, no done; a new stream then reads the original data.
REQ-043 Bench SHALL cover: start with wr_en addr0=16'hBEEF on lane 1 in the same cycle -> beat 0 lane 1 = 16'hBEEF.
